// File: rtl/branch_ctrl.sv
// Run-state sequencer and branch decoder driving the program counter's branch port.
// Optional BRANCH_STATS_EN adds a saturating taken-branch counter output (TakenCnt).
module branch_ctrl #(
  parameter int AW        = 10,
  parameter int IW        = 9,
  parameter int LUT_DEPTH = 32,
  parameter int CW        = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [IW-1:0] Instr,
  input  logic          ALU_flag,
  input  logic          LutWe,
  input  logic [4:0]    LutAddr,
  input  logic [AW-1:0] LutData,
  output logic          BranchAbsEn,
  output logic          BranchRelEn,
  output logic [AW-1:0] Target,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] CycleCnt,
`ifdef BRANCH_STATS_EN
  output logic [CW-1:0] TakenCnt,
`endif
  output logic [1:0]    DbgState
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, HALT} state_t;

  state_t        state;
  logic [AW-1:0] lut [LUT_DEPTH];

  logic [2:0] opcode;
  logic       inRun;
  logic       isBranch;
  logic       taken;
  logic       isHalt;

  assign opcode   = Instr[8:6];
  assign inRun    = (state == RUN);
  assign isBranch = (opcode[2:1] == 2'b11);
  assign taken    = inRun && ((opcode == 3'b110) || ((opcode == 3'b111) && ALU_flag));
  assign isHalt   = (Instr == IW'(9'b000_111111));

  // Instr[5] picks relative vs absolute, so the two enables are exclusive by construction.
  assign BranchAbsEn = taken && !Instr[5];
  assign BranchRelEn = taken &&  Instr[5];
  assign Target      = (inRun && isBranch) ? lut[Instr[4:0]] : '0;
  assign DbgState    = state;

  // Start forces ARMED from every state, which also gives restart priority over halt.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      CycleCnt <= '0;
    end else if (Start) begin
      state    <= ARMED;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      CycleCnt <= '0;
    end else begin
      case (state)
        IDLE: ;
        ARMED: begin
          state <= RUN;
          Busy  <= 1'b1;
        end
        RUN: begin
          if (CycleCnt != '1) CycleCnt <= CycleCnt + CW'(1);
          if (isHalt) begin
            state <= HALT;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end

  // Writes land at the edge, so a same-cycle read still sees the old entry.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
    end else if (LutWe) begin
      lut[LutAddr] <= LutData;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      TakenCnt <= '0;
    end else if (Start) begin
      TakenCnt <= '0;
    end else if (taken && (TakenCnt != '1)) begin
      TakenCnt <= TakenCnt + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: a rule-level model predicts every cycle's outputs into a queue,
// a negedge monitor pops and compares. CW is shrunk so counter saturation is reachable.
module tb_branch_ctrl;

  localparam int AW   = 10;
  localparam int IW   = 9;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;
`ifdef BRANCH_STATS_EN
  localparam int VW = 2 + AW + 2 + 2 * CW;
`else
  localparam int VW = 2 + AW + 2 + CW;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_HALT  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [IW-1:0] instr;
  logic          aluFlag;
  logic          lutWe;
  logic [4:0]    lutAddr;
  logic [AW-1:0] lutData;
  logic          branchAbsEn;
  logic          branchRelEn;
  logic [AW-1:0] target;
  logic          busy;
  logic          done;
  logic [CW-1:0] cycleCnt;
  logic [1:0]    dbgState;
`ifdef BRANCH_STATS_EN
  logic [CW-1:0] takenCnt;
`endif

  logic [VW-1:0] act;
  logic [VW-1:0] exp_q[$];

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int mMode;
  int mLut[32];
  int mCyc;
  int mTaken;

  branch_ctrl #(.AW(AW), .IW(IW), .LUT_DEPTH(32), .CW(CW)) dut (
    .Clk(clk),
    .Reset(reset),
    .Start(start),
    .Instr(instr),
    .ALU_flag(aluFlag),
    .LutWe(lutWe),
    .LutAddr(lutAddr),
    .LutData(lutData),
    .BranchAbsEn(branchAbsEn),
    .BranchRelEn(branchRelEn),
    .Target(target),
    .Busy(busy),
    .Done(done),
    .CycleCnt(cycleCnt),
`ifdef BRANCH_STATS_EN
    .TakenCnt(takenCnt),
`endif
    .DbgState(dbgState)
  );

`ifdef BRANCH_STATS_EN
  assign act = {branchAbsEn, branchRelEn, target, busy, done, cycleCnt, takenCnt};
`else
  assign act = {branchAbsEn, branchRelEn, target, busy, done, cycleCnt};
`endif

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic bit model_taken();
    int op;
    op = int'(instr[8:6]);
    return (mMode == M_RUN) && ((op == 6) || ((op == 7) && aluFlag));
  endfunction

  function automatic logic [VW-1:0] expected();
    int op;
    bit tk;
    int tgt;
    op  = int'(instr[8:6]);
    tk  = model_taken();
    tgt = 0;
    if ((mMode == M_RUN) && (op >= 6)) tgt = mLut[instr[4:0]];
`ifdef BRANCH_STATS_EN
    return {tk && !instr[5], tk && instr[5], AW'(tgt), mMode == M_RUN, mMode == M_HALT,
            CW'(mCyc), CW'(mTaken)};
`else
    return {tk && !instr[5], tk && instr[5], AW'(tgt), mMode == M_RUN, mMode == M_HALT,
            CW'(mCyc)};
`endif
  endfunction

  task automatic model_reset();
    mMode  = M_IDLE;
    mCyc   = 0;
    mTaken = 0;
    for (int i = 0; i < 32; i++) mLut[i] = 0;
  endtask

  task automatic model_edge();
    bit tk;
    tk = model_taken();
    if (start) begin
      mMode  = M_ARMED;
      mCyc   = 0;
      mTaken = 0;
    end else if (mMode == M_ARMED) begin
      mMode = M_RUN;
    end else if (mMode == M_RUN) begin
      if (mCyc < CMAX) mCyc++;
      if (tk && mTaken < CMAX) mTaken++;
      if (instr == 9'b000_111111) mMode = M_HALT;
    end
    if (lutWe) mLut[lutAddr] = int'(lutData);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit s, input logic [IW-1:0] in, input bit f,
                      input bit we = 1'b0, input logic [4:0] a = 5'd0,
                      input logic [AW-1:0] d = '0);
    start   = s;
    instr   = in;
    aluFlag = f;
    lutWe   = we;
    lutAddr = a;
    lutData = d;
    exp_q.push_back(expected());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_now(input string name, input logic [VW-1:0] a, input logic [VW-1:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, a, e);
    end
  endtask

  task automatic async_reset_mid_cycle();
    @(negedge clk);
    #1;
    check_now("pre_reset_abs_en", VW'(branchAbsEn), VW'(1));
    reset = 1'b1;
    #1;
    check_now("async_reset_outputs", act, '0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic random_step();
    logic [IW-1:0] in;
    int r;
    r = $urandom_range(0, 99);
    if (r < 45)      in = {2'b11, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31))};
    else if (r < 50) in = 9'b000_111111;
    else             in = IW'($urandom);
    step($urandom_range(0, 99) < 6, in, 1'($urandom_range(0, 1)),
         $urandom_range(0, 99) < 25, 5'($urandom_range(0, 31)), AW'($urandom));
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [VW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compared++;
        if (act !== e) begin
          mismatched++;
          $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    instr   = '0;
    aluFlag = 1'b0;
    lutWe   = 1'b0;
    lutAddr = '0;
    lutData = '0;
    model_reset();
    #2;
    check_now("reset_before_clock", act, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Arm for two cycles, release, then five idle instructions in RUN
    step(1, 9'h000, 0);
    step(1, 9'h000, 0);
    step(0, 9'h000, 0);
    repeat (5) step(0, 9'h000, 0);

    // Every LUT entry reads zero after reset
    for (int i = 0; i < 32; i++) step(0, {3'b110, 1'b0, 5'(i)}, 0);

    // Absolute unconditional branch through LUT[3]
    step(0, 9'h000, 0, 1, 5'd3, 10'd200);
    step(0, 9'b110_0_00011, 0);

    // Conditional relative branch through LUT[4], flag low then high
    step(0, 9'h000, 0, 1, 5'd4, 10'h3FE);
    step(0, 9'b111_1_00100, 0);
    step(0, 9'b111_1_00100, 1);

    // Same-cycle write/read returns the old entry
    step(0, 9'b110_0_00011, 0, 1, 5'd3, 10'd77);
    step(0, 9'b110_0_00011, 0);

    // Halt, branches ignored in HALT, then re-run from zero
    step(0, 9'b000_111111, 0);
    repeat (3) step(0, 9'b110_0_00011, 1);
    step(1, 9'h000, 0);
    step(0, 9'h000, 0);
    repeat (4) step(0, 9'h000, 0);

    // Three taken branches with one not-taken in between
    step(0, 9'b110_0_00011, 0);
    step(0, 9'b111_1_00100, 1);
    step(0, 9'b111_0_00100, 0);
    step(0, 9'b110_1_00011, 0);
    step(0, 9'h000, 0);

    // Restart wins over halt in the same cycle
    step(1, 9'b000_111111, 0);
    step(0, 9'h000, 0);
    step(0, 9'h000, 0);

    // Counter saturation
    repeat (40) step(0, 9'b110_0_00011, 0);

    // Asynchronous reset while an absolute branch is being presented
    step(0, 9'b110_0_00011, 0);
    async_reset_mid_cycle();
    step(1, 9'h000, 0);
    step(0, 9'h000, 0);
    step(0, 9'b110_0_00011, 0);

    // Randomised traffic
    repeat (400) random_step();

    step(0, 9'h000, 0);
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
